// File: rtl/pipe_skid_reg_pkg.sv
// Shared types and defaults for the elastic skid pipeline register.
//   skid_state_t   : fill level of the stage; the encoding doubles as occupancy
//   DATA_W_DEFAULT : default payload width (instr/ctrl bundle)
package pipe_pkg;
  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} skid_state_t;
  localparam int DATA_W_DEFAULT = 32;
endpackage

// File: rtl/pipe_skid_reg_if.sv
// Ready/valid bus around one skid stage.
//   in_valid/in_ready/in_data    : upstream (producer) handshake
//   out_valid/out_ready/out_data : downstream (consumer) handshake
//   occupancy                    : entries held by the stage (0..2)
// modport slave  : the stage itself
// modport master : the environment driving producer and consumer sides
interface pipe_skid_reg_if #(parameter int WIDTH = pipe_pkg::DATA_W_DEFAULT);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [1:0]       occupancy;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, occupancy
  );
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, occupancy
  );
endinterface

// File: rtl/pipe_skid_reg_flopenr.sv
// Enabled register with synchronous active-high reset to zero.
//   clk   : clock
//   reset : synchronous clear
//   en    : load d on the rising edge
//   d / q : data in / registered data out
module flopenr #(parameter int WIDTH = 32) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  always_ff @(posedge clk) begin
    if (reset)   q <= '0;
    else if (en) q <= d;
  end
endmodule

// File: rtl/pipe_skid_reg.sv
// Elastic pipeline stage: main + skid entries so in_ready is a flop output
// and out_ready never reaches in_ready combinationally. Full throughput when
// the consumer never stalls.
//   clk   : clock
//   reset : synchronous, active-high; drops all entries, out_data -> 0
//   flush : discard held entries (redirect); an output xfer that cycle still
//           completes, an input accepted that cycle is dropped
//   bus   : ready/valid handshake on both sides plus occupancy
module pipe_skid_reg
  import pipe_pkg::*;
#(parameter int WIDTH = DATA_W_DEFAULT) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush,
  pipe_skid_reg_if.slave bus
);
  skid_state_t      state_q, state_d;
  logic             in_ready_q, in_ready_d;
  logic             main_en, skid_en, main_from_skid;
  logic [WIDTH-1:0] main_q, skid_q, main_d;
  logic             in_xfer, out_xfer, out_valid;

  assign out_valid = (state_q != EMPTY);
  assign in_xfer   = bus.in_valid & in_ready_q;
  assign out_xfer  = out_valid & bus.out_ready;

  always_comb begin
    state_d        = state_q;
    main_en        = 1'b0;
    skid_en        = 1'b0;
    main_from_skid = 1'b0;
    unique case (state_q)
      EMPTY: if (in_xfer) begin
        state_d = ONE;
        main_en = 1'b1;
      end
      ONE: begin
        if (in_xfer && out_xfer) begin
          main_en = 1'b1;
        end else if (in_xfer) begin
          state_d = TWO;
          skid_en = 1'b1;
        end else if (out_xfer) begin
          state_d = EMPTY;
        end
      end
      TWO: if (out_xfer) begin
        state_d        = ONE;
        main_en        = 1'b1;
        main_from_skid = 1'b1;
      end
      default: state_d = EMPTY;
    endcase
    // Flush wins over handshakes; loads are suppressed so the dropped input
    // cannot leak into main/skid.
    if (flush) begin
      state_d = EMPTY;
      main_en = 1'b0;
      skid_en = 1'b0;
    end
    in_ready_d = (state_d != TWO);
  end

  assign main_d = main_from_skid ? skid_q : bus.in_data;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= EMPTY;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      in_ready_q <= in_ready_d;
    end
  end

  flopenr #(.WIDTH(WIDTH)) u_main (
    .clk(clk), .reset(reset), .en(main_en), .d(main_d), .q(main_q)
  );
  flopenr #(.WIDTH(WIDTH)) u_skid (
    .clk(clk), .reset(reset), .en(skid_en), .d(bus.in_data), .q(skid_q)
  );

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid;
  assign bus.out_data  = main_q;
  assign bus.occupancy = state_q;

  a_no_in_when_full: assert property (@(posedge clk) disable iff (reset)
    !(state_q == TWO && in_xfer));
  a_stall_stable: assert property (@(posedge clk) disable iff (reset)
    (out_valid && !bus.out_ready && !flush) |=> (out_valid && $stable(main_q)));
  a_occ_legal: assert property (@(posedge clk) disable iff (reset)
    state_q != 2'd3);
endmodule
